// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register file write arbiter and its MDU result buffer.
// The buffered request struct is sized by the package defaults below.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;
    localparam int LINK_REG   = 31;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] dst;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/mdu_result_fifo.sv
// Small FIFO holding completed MDU results until the write port is granted to them.
// The head entry is read combinationally, so a result pushed at one edge can be granted in the next cycle.
module mdu_result_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback and buffered MDU results, and
// tracks in-flight MDU destinations so decode stalls on RAW/WAW hazards against them.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic              wb_link,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_dst,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic [ADDR_W-1:0] dec_dst,
    input  logic              dec_is_mdu,
    output logic              dec_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int SCNT_W   = $clog2(STARVE_MAX + 1);

    wr_req_t             head;
    logic                buf_full;
    logic                buf_empty;
    logic                mdu_push;
    logic                mdu_grant;
    logic                wb_grant;
    logic [ADDR_W-1:0]   wb_eff_dst;
    logic [SCNT_W-1:0]   starve_cnt_reg;
    logic [SCNT_W-1:0]   starve_cnt_next;
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;
    logic                pending_set;

    assign mdu_ready = !buf_full;
    assign mdu_push  = mdu_valid && !buf_full;

    mdu_result_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mdu_push),
        .push_data ('{dst: mdu_dst, data: mdu_data}),
        .pop       (mdu_grant),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign wb_eff_dst = wb_link ? ADDR_W'(LINK_REG) : wb_dst;
    assign mdu_grant  = !buf_empty && (!wb_valid || starve_cnt_reg == SCNT_W'(STARVE_MAX));
    assign wb_grant   = wb_valid && !mdu_grant;
    assign wb_stall   = wb_valid && mdu_grant;

    // Counts WB wins only while an MDU result is waiting; saturates so the MDU wins next.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (mdu_grant || buf_empty) begin
            starve_cnt_next = '0;
        end else if (wb_grant && starve_cnt_reg != SCNT_W'(STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    assign dec_stall   = dec_valid && (pending_reg[dec_rs] | pending_reg[dec_rt] | pending_reg[dec_dst]);
    assign pending_set = dec_valid && dec_is_mdu && !dec_stall && (dec_dst != '0);

    // The WAW stall guarantees a set and a clear never target the same bit in one cycle.
    always_comb begin
        pending_next = pending_reg;
        if (mdu_grant)   pending_next[head.dst] = 1'b0;
        if (pending_set) pending_next[dec_dst]  = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            pending_reg    <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            pending_reg    <= pending_next;
            rf_we          <= 1'b0;
            // Register 0 requests are still consumed, they just never reach the file.
            if (mdu_grant) begin
                rf_we    <= (head.dst != '0);
                rf_waddr <= head.dst;
                rf_wdata <= head.data;
            end else if (wb_grant) begin
                rf_we    <= (wb_eff_dst != '0);
                rf_waddr <= wb_eff_dst;
                rf_wdata <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: link/r0 handling, starvation limit,
// scoreboard RAW/WAW stalls, buffer backpressure and asynchronous reset.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dst = '0;
    logic        wb_link = 1'b0;
    logic [63:0] wb_data = '0;
    logic        wb_stall;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_dst = '0;
    logic [63:0] mdu_data = '0;
    logic        dec_valid = 1'b0;
    logic [4:0]  dec_rs = '0;
    logic [4:0]  dec_rt = '0;
    logic [4:0]  dec_dst = '0;
    logic        dec_is_mdu = 1'b0;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int n_pass = 0;
    int n_total = 0;

    regfile_write_arbiter #(
        .DATA_W     (64),
        .ADDR_W     (5),
        .BUF_DEPTH  (2),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_link    (wb_link),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_dst    (mdu_dst),
        .mdu_data   (mdu_data),
        .dec_valid  (dec_valid),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_dst    (dec_dst),
        .dec_is_mdu (dec_is_mdu),
        .dec_stall  (dec_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs changed here apply to the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset / idle
        #22 rst_n = 1'b1;
        tick();
        chk("reset_rf_we",     64'(rf_we), 64'd0);
        chk("reset_rf_waddr",  64'(rf_waddr), 64'd0);
        chk("reset_rf_wdata",  rf_wdata, 64'd0);
        chk("reset_mdu_ready", 64'(mdu_ready), 64'd1);
        chk("reset_wb_stall",  64'(wb_stall), 64'd0);
        chk("reset_dec_stall", 64'(dec_stall), 64'd0);

        // Jump-and-link forces destination 31
        wb_valid = 1'b1; wb_link = 1'b1; wb_dst = 5'd5; wb_data = 64'hAB;
        #1 chk("link_wb_stall", 64'(wb_stall), 64'd0);
        tick();
        chk("link_rf_we",    64'(rf_we), 64'd1);
        chk("link_rf_waddr", 64'(rf_waddr), 64'd31);
        chk("link_rf_wdata", rf_wdata, 64'hAB);

        // Register 0 write is acknowledged but suppressed
        wb_link = 1'b0; wb_dst = 5'd0; wb_data = 64'hCD;
        #1 chk("r0_wb_stall", 64'(wb_stall), 64'd0);
        tick();
        chk("r0_rf_we", 64'(rf_we), 64'd0);

        // Starvation: WB held, one MDU result to r7
        wb_dst = 5'd3; wb_data = 64'h11;
        mdu_valid = 1'b1; mdu_dst = 5'd7; mdu_data = 64'h77;
        tick();
        mdu_valid = 1'b0;
        chk("starve_wb_rf_waddr", 64'(rf_waddr), 64'd3);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("starve_wb_grant%0d", i), 64'(wb_stall), 64'd0);
            tick();
        end
        chk("starve_mdu_stall", 64'(wb_stall), 64'd1);
        tick();
        chk("starve_rf_we",    64'(rf_we), 64'd1);
        chk("starve_rf_waddr", 64'(rf_waddr), 64'd7);
        chk("starve_rf_wdata", rf_wdata, 64'h77);
        chk("starve_after",    64'(wb_stall), 64'd0);
        wb_valid = 1'b0;
        tick();

        // Scoreboard RAW: MDU op to r9, then a reader of r9
        dec_valid = 1'b1; dec_is_mdu = 1'b1; dec_dst = 5'd9; dec_rs = 5'd1; dec_rt = 5'd2;
        #1 chk("raw_issue_nostall", 64'(dec_stall), 64'd0);
        tick();
        dec_is_mdu = 1'b0; dec_rs = 5'd9; dec_dst = 5'd10;
        #1 chk("raw_stall", 64'(dec_stall), 64'd1);
        tick();
        chk("raw_stall_hold", 64'(dec_stall), 64'd1);

        // Scoreboard WAW and r0 destination
        dec_rs = 5'd1; dec_dst = 5'd9;
        #1 chk("waw_stall", 64'(dec_stall), 64'd1);
        dec_is_mdu = 1'b1; dec_dst = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0;
        #1 chk("r0_mdu_nostall", 64'(dec_stall), 64'd0);
        tick();
        dec_is_mdu = 1'b0;
        #1 chk("r0_never_pending", 64'(dec_stall), 64'd0);

        // r9 result arrives; reader stalls until the cycle after its grant
        dec_rs = 5'd9;
        mdu_valid = 1'b1; mdu_dst = 5'd9; mdu_data = 64'h99;
        #1 chk("raw_before_push", 64'(dec_stall), 64'd1);
        tick();
        mdu_valid = 1'b0;
        #1 chk("raw_grant_cycle", 64'(dec_stall), 64'd1);
        tick();
        chk("raw_released",  64'(dec_stall), 64'd0);
        chk("raw_rf_we",     64'(rf_we), 64'd1);
        chk("raw_rf_waddr",  64'(rf_waddr), 64'd9);
        chk("raw_rf_wdata",  rf_wdata, 64'h99);

        // Backpressure: fill the buffer under WB pressure, then reset mid-sequence
        wb_valid = 1'b1; wb_dst = 5'd4; wb_data = 64'h44;
        mdu_valid = 1'b1; mdu_dst = 5'd12; mdu_data = 64'h1;
        dec_valid = 1'b1; dec_is_mdu = 1'b1; dec_dst = 5'd12; dec_rs = 5'd0; dec_rt = 5'd0;
        #1 chk("bp_ready0", 64'(mdu_ready), 64'd1);
        tick();
        dec_valid = 1'b0; dec_is_mdu = 1'b0;
        mdu_dst = 5'd13; mdu_data = 64'h2;
        #1 chk("bp_ready1", 64'(mdu_ready), 64'd1);
        tick();
        mdu_valid = 1'b0;
        #1 chk("bp_full_ready", 64'(mdu_ready), 64'd0);
        chk("bp_full_wb_stall", 64'(wb_stall), 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mdu_ready", 64'(mdu_ready), 64'd1);
        chk("rst_wb_stall", 64'(wb_stall), 64'd0);
        chk("rst_rf_we",    64'(rf_we), 64'd0);
        wb_valid = 1'b0;
        dec_valid = 1'b1; dec_rs = 5'd12; dec_dst = 5'd20;
        #1 rst_n = 1'b1;
        #1 chk("rst_pending_clear", 64'(dec_stall), 64'd0);
        tick();
        chk("post_rst_rf_we",     64'(rf_we), 64'd0);
        chk("post_rst_dec_stall", 64'(dec_stall), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
